fifo_wr_arbiter: RTL and testbench

Round-robin write-side arbiter that shares the single push port of the dual-clock FIFO among `N_REQ` producers in the write clock domain. Each producer presents words on a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst and drives the FIFO `push`/`data_in` pair. It also honours `full` and keeps a wrapping count of accepted words.

---
 rtl/fifo_wr_arbiter.sv | 151 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin sharing of the FIFO push port among N_REQ
// write-domain producers, with bounded bursts and a wrapping push counter.
module fifo_wr_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned W_DATA    = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                       wr_clk,
    input  logic                       wr_rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*W_DATA-1:0]    req_data,
    input  logic [N_REQ-1:0]           req_last,
    output logic [N_REQ-1:0]           req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_push,
    output logic [W_DATA-1:0]          fifo_data,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy,
    output logic [15:0]                push_count
);

    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned BC_W  = $clog2(MAX_BURST + 1);
    localparam int unsigned CNT_W = 16;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [BC_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]   push_count_q, push_count_d;

    logic [W_DATA-1:0]  data_arr [N_REQ];
    logic               pick_found;
    logic [ID_W-1:0]    pick_idx;
    logic [ID_W-1:0]    pick_cand;
    logic               grant_valid;
    logic               accept;
    logic [BC_W-1:0]    beat_inc;
    logic [ID_W-1:0]    grant_next;

    // Unpack the flat requester data bus into one word per requester.
    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*W_DATA +: W_DATA];
    end

    // Round-robin search: first valid index at or after rr_ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_cand  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            pick_cand = ID_W'((32'(rr_ptr_q) + k) % N_REQ);
            if (!pick_found && req_valid[pick_cand]) begin
                pick_found = 1'b1;
                pick_idx   = pick_cand;
            end
        end
    end

    // Beat qualification and helper increments for the granted requester.
    always_comb begin
        grant_valid = req_valid[grant_id_q];
        accept      = (state_q == S_BURST) && grant_valid && !fifo_full;
        beat_inc    = beat_cnt_q + BC_W'(1);
        grant_next  = (32'(grant_id_q) == N_REQ - 1) ? '0 : grant_id_q + ID_W'(1);
    end

    // State register.
    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath-next logic; release is only judged while not full.
    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        rr_ptr_d     = rr_ptr_q;
        beat_cnt_d   = beat_cnt_q;
        push_count_d = push_count_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    state_d    = S_BURST;
                    grant_id_d = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            S_BURST: begin
                if (!fifo_full) begin
                    if (grant_valid) begin
                        beat_cnt_d   = beat_inc;
                        push_count_d = push_count_q + CNT_W'(1);
                        if (req_last[grant_id_q] || (beat_inc == BC_W'(MAX_BURST))) begin
                            state_d  = S_IDLE;
                            rr_ptr_d = grant_next;
                        end
                    end else begin
                        state_d  = S_IDLE;
                        rr_ptr_d = grant_next;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Combinational push-side outputs; only the granted requester is acknowledged.
    always_comb begin
        req_ready = '0;
        fifo_push = 1'b0;
        fifo_data = '0;
        if (state_q == S_BURST) begin
            fifo_data = data_arr[grant_id_q];
            if (accept) begin
                fifo_push             = 1'b1;
                req_ready[grant_id_q] = 1'b1;
            end
        end
    end

    // Grant, round-robin pointer, beat and push counters.
    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            grant_id_q   <= '0;
            rr_ptr_q     <= '0;
            beat_cnt_q   <= '0;
            push_count_q <= '0;
        end else begin
            grant_id_q   <= grant_id_d;
            rr_ptr_q     <= rr_ptr_d;
            beat_cnt_q   <= beat_cnt_d;
            push_count_q <= push_count_d;
        end
    end

    assign grant_id   = grant_id_q;
    assign busy       = (state_q == S_BURST);
    assign push_count = push_count_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: table-driven cycle checks plus a data scoreboard for
// the round-robin FIFO write arbiter, with hand-written reset and wrap cases.
module tb_fifo_wr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned WD = 8;

    typedef struct packed {
        logic        rst;
        logic [3:0]  valid;
        logic [3:0]  last;
        logic        full;
        logic        push;
        logic [1:0]  grant;
        logic        busy;
        logic        chk;
        logic [15:0] cnt;
    } vec_t;

    logic             clk = 1'b0;
    logic             wr_rst;
    logic [N-1:0]     req_valid;
    logic [N*WD-1:0]  req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic             fifo_full;
    logic             fifo_push;
    logic [WD-1:0]    fifo_data;
    logic [1:0]       grant_id;
    logic             busy;
    logic [15:0]      push_count;

    int               n_cmp = 0;
    int               n_err = 0;
    int               cyc_n = 0;
    logic [WD-1:0]    sb [$];
    vec_t             vt [$];

    fifo_wr_arbiter #(.N_REQ(4), .W_DATA(8), .MAX_BURST(4)) dut (
        .wr_clk     (clk),
        .wr_rst     (wr_rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_push  (fifo_push),
        .fifo_data  (fifo_data),
        .grant_id   (grant_id),
        .busy       (busy),
        .push_count (push_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int tag);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (step %0d): got 0x%0h expected 0x%0h", name, tag, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] valid, input logic [3:0] last, input logic full,
                                input logic push, input logic [1:0] grant, input logic busy,
                                input logic chk_cnt = 1'b0, input logic [15:0] cnt = 16'h0);
        vec_t v;
        v.rst = 1'b0; v.valid = valid; v.last = last; v.full = full;
        v.push = push; v.grant = grant; v.busy = busy; v.chk = chk_cnt; v.cnt = cnt;
        return v;
    endfunction

    function automatic vec_t mk_rst();
        vec_t v;
        v = mk(4'b0, 4'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 16'h0);
        v.rst = 1'b1;
        return v;
    endfunction

    function automatic logic [WD-1:0] word_of(input int req, input int c);
        return WD'(req * 16 + (c % 16));
    endfunction

    // Drive one row after the active edge, then check outputs on the falling edge.
    task automatic apply(input vec_t t, input int tag);
        logic [WD-1:0] exp_data;
        logic [3:0]    exp_ready;
        @(posedge clk);
        #1;
        cyc_n++;
        wr_rst    = t.rst;
        req_valid = t.valid;
        req_last  = t.last;
        fifo_full = t.full;
        for (int i = 0; i < 4; i++) req_data[i*WD +: WD] = word_of(i, cyc_n);
        if (t.push) sb.push_back(word_of(int'(t.grant), cyc_n));
        exp_ready = t.push ? (4'b0001 << t.grant) : 4'b0000;
        exp_data  = t.busy ? word_of(int'(t.grant), cyc_n) : '0;
        @(negedge clk);
        chk("fifo_push", 32'(fifo_push), 32'(t.push), tag);
        chk("req_ready", 32'(req_ready), 32'(exp_ready), tag);
        chk("busy", 32'(busy), 32'(t.busy), tag);
        chk("grant_id", 32'(grant_id), 32'(t.grant), tag);
        chk("fifo_data", 32'(fifo_data), 32'(exp_data), tag);
        if (t.chk) chk("push_count", 32'(push_count), 32'(t.cnt), tag);
    endtask

    // Scoreboard: every observed push must match the next expected word in order.
    always @(negedge clk) begin
        if (fifo_push === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_push", 32'(fifo_data), 32'hFFFF_FFFF, cyc_n);
            end else begin
                chk("sb_order", 32'(fifo_data), 32'(sb.pop_front()), cyc_n);
            end
        end
    end

    initial begin
        wr_rst    = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;

        // Single requester 2, six words, last on the sixth.
        vt.push_back(mk_rst());
        vt.push_back(mk(4'b0100, 4'b0000, 0, 0, 2'd0, 0, 1, 16'd0));
        for (int b = 0; b < 4; b++) vt.push_back(mk(4'b0100, 4'b0000, 0, 1, 2'd2, 1));
        vt.push_back(mk(4'b0100, 4'b0000, 0, 0, 2'd2, 0));
        vt.push_back(mk(4'b0100, 4'b0000, 0, 1, 2'd2, 1));
        vt.push_back(mk(4'b0100, 4'b0100, 0, 1, 2'd2, 1));
        vt.push_back(mk(4'b0000, 4'b0000, 0, 0, 2'd2, 0, 1, 16'd6));
        // All four requesters continuously valid.
        vt.push_back(mk_rst());
        vt.push_back(mk(4'b1111, 4'b0000, 0, 0, 2'd0, 0));
        for (int g = 0; g < 4; g++) begin
            for (int b = 0; b < 4; b++) vt.push_back(mk(4'b1111, 4'b0000, 0, 1, 2'(g), 1));
            vt.push_back(mk(4'b1111, 4'b0000, 0, 0, 2'(g), 0, (g == 3), 16'd16));
        end
        vt.push_back(mk(4'b1111, 4'b0000, 0, 1, 2'd0, 1));
        vt.push_back(mk(4'b0000, 4'b0000, 0, 0, 2'd0, 1));
        vt.push_back(mk(4'b0000, 4'b0000, 0, 0, 2'd0, 0, 1, 16'd17));
        // Full for three cycles mid-burst of requester 1, valid dropping while full.
        vt.push_back(mk_rst());
        vt.push_back(mk(4'b0010, 4'b0000, 0, 0, 2'd0, 0));
        vt.push_back(mk(4'b0010, 4'b0000, 0, 1, 2'd1, 1));
        vt.push_back(mk(4'b0010, 4'b0000, 1, 0, 2'd1, 1));
        vt.push_back(mk(4'b0000, 4'b0000, 1, 0, 2'd1, 1));
        vt.push_back(mk(4'b0010, 4'b0000, 1, 0, 2'd1, 1));
        for (int b = 0; b < 3; b++) vt.push_back(mk(4'b0010, 4'b0000, 0, 1, 2'd1, 1));
        vt.push_back(mk(4'b0000, 4'b0000, 0, 0, 2'd1, 0, 1, 16'd4));
        // Requester 3 releases after two words; pointer wrap on later grants.
        vt.push_back(mk_rst());
        vt.push_back(mk(4'b1000, 4'b0000, 0, 0, 2'd0, 0));
        vt.push_back(mk(4'b1000, 4'b0000, 0, 1, 2'd3, 1));
        vt.push_back(mk(4'b1000, 4'b0000, 0, 1, 2'd3, 1));
        vt.push_back(mk(4'b0110, 4'b0000, 0, 0, 2'd3, 1));
        vt.push_back(mk(4'b0110, 4'b0000, 0, 0, 2'd3, 0));
        vt.push_back(mk(4'b0110, 4'b0000, 0, 1, 2'd1, 1));
        vt.push_back(mk(4'b0100, 4'b0000, 0, 0, 2'd1, 1));
        vt.push_back(mk(4'b0100, 4'b0000, 0, 0, 2'd1, 0));
        vt.push_back(mk(4'b0100, 4'b0000, 0, 1, 2'd2, 1));
        vt.push_back(mk(4'b0100, 4'b0100, 0, 1, 2'd2, 1));
        vt.push_back(mk(4'b0011, 4'b0000, 0, 0, 2'd2, 0));
        vt.push_back(mk(4'b0011, 4'b0001, 0, 1, 2'd0, 1));
        vt.push_back(mk(4'b0010, 4'b0000, 0, 0, 2'd0, 0));
        vt.push_back(mk(4'b0010, 4'b0010, 0, 1, 2'd1, 1));
        vt.push_back(mk(4'b0000, 4'b0000, 0, 0, 2'd1, 0, 1, 16'd7));

        for (int i = 0; i < vt.size(); i++) apply(vt[i], i);

        // Asynchronous reset in the middle of a burst from requester 2 (rr_ptr=1).
        apply(mk_rst(), 1000);
        apply(mk(4'b0001, 4'b0000, 0, 0, 2'd0, 0), 1001);
        apply(mk(4'b0001, 4'b0001, 0, 1, 2'd0, 1), 1002);
        apply(mk(4'b0100, 4'b0000, 0, 0, 2'd0, 0), 1003);
        apply(mk(4'b0100, 4'b0000, 0, 1, 2'd2, 1), 1004);
        apply(mk(4'b0100, 4'b0000, 0, 1, 2'd2, 1), 1005);
        @(posedge clk);
        #2;
        wr_rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0, 1006);
        chk("rst_push", 32'(fifo_push), 32'd0, 1006);
        chk("rst_ready", 32'(req_ready), 32'd0, 1006);
        chk("rst_data", 32'(fifo_data), 32'd0, 1006);
        chk("rst_grant", 32'(grant_id), 32'd0, 1006);
        chk("rst_count", 32'(push_count), 32'd0, 1006);
        req_valid = '0;
        @(posedge clk);
        #3;
        wr_rst = 1'b0;
        apply(mk(4'b0101, 4'b0000, 0, 0, 2'd0, 0, 1, 16'd0), 1007);
        apply(mk(4'b0101, 4'b0000, 0, 1, 2'd0, 1), 1008);
        apply(mk(4'b0000, 4'b0000, 0, 0, 2'd0, 1), 1009);
        apply(mk(4'b0000, 4'b0000, 0, 0, 2'd0, 0, 1, 16'd1), 1010);

        // push_count wrap from 0xFFFE through 0xFFFF to 0x0001.
        apply(mk_rst(), 2000);
        force dut.push_count_q = 16'hFFFE;
        apply(mk(4'b0001, 4'b0000, 0, 0, 2'd0, 0, 1, 16'hFFFE), 2001);
        release dut.push_count_q;
        apply(mk(4'b0001, 4'b0000, 0, 1, 2'd0, 1, 1, 16'hFFFE), 2002);
        apply(mk(4'b0001, 4'b0000, 0, 1, 2'd0, 1, 1, 16'hFFFF), 2003);
        apply(mk(4'b0001, 4'b0001, 0, 1, 2'd0, 1, 1, 16'h0000), 2004);
        apply(mk(4'b0000, 4'b0000, 0, 0, 2'd0, 0, 1, 16'h0001), 2005);

        @(negedge clk);
        chk("sb_leftover", 32'(sb.size()), 32'd0, 3000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
